// File: rtl/intra_resid_pkg.sv
// Shared constants for the intra residual generator.
//   LANES      pixel lanes per beat
//   PIX_W      unsigned pixel width
//   RES_W      signed residual width (one extra bit for the sign)
//   BEAT_SAD_W width of one beat's SAD (32 * 255 = 8160)
//   SAD_W      width of a block SAD (32 * 32 * 255 = 261120)
//   CNT_W      beat counter width (covers up to 32 beats per block)
package intra_resid_pkg;

  localparam int unsigned LANES      = 32;
  localparam int unsigned PIX_W      = 8;
  localparam int unsigned RES_W      = 9;
  localparam int unsigned BEAT_SAD_W = 13;
  localparam int unsigned SAD_W      = 18;
  localparam int unsigned CNT_W      = 5;

  localparam int unsigned PIX_BUS_W = LANES * PIX_W;
  localparam int unsigned RES_BUS_W = LANES * RES_W;

endpackage

// File: rtl/resid_lane_sad.sv
// Combinational residual and beat-SAD datapath.
// Ports:
//   ref_dat   in  256  reference pixels, lane i at [8i+7:8i], unsigned
//   pred_dat  in  256  predicted pixels, same layout
//   resid     out 288  ref - pred per lane, lane i at [9i+8:9i], two's complement
//   beat_sad  out 13   sum over lanes of |ref - pred|
module resid_lane_sad
  import intra_resid_pkg::*;
(
  input  logic [PIX_BUS_W-1:0]  ref_dat,
  input  logic [PIX_BUS_W-1:0]  pred_dat,
  output logic [RES_BUS_W-1:0]  resid,
  output logic [BEAT_SAD_W-1:0] beat_sad
);

  // Adder tree levels, 32 -> 16 -> 8 -> 4 -> 2 -> 1.
  logic [BEAT_SAD_W-1:0] lvl0 [LANES];
  logic [BEAT_SAD_W-1:0] lvl1 [LANES/2];
  logic [BEAT_SAD_W-1:0] lvl2 [LANES/4];
  logic [BEAT_SAD_W-1:0] lvl3 [LANES/8];
  logic [BEAT_SAD_W-1:0] lvl4 [LANES/16];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] p;
    assign r = ref_dat[i*PIX_W +: PIX_W];
    assign p = pred_dat[i*PIX_W +: PIX_W];
    // Zero-extend both operands so the 9-bit difference carries the sign.
    assign resid[i*RES_W +: RES_W] = {1'b0, r} - {1'b0, p};
    // Magnitude taken from the unsigned operands directly, avoiding a negate.
    assign lvl0[i] = (r >= p) ? BEAT_SAD_W'(r - p) : BEAT_SAD_W'(p - r);
  end

  for (genvar i = 0; i < LANES/2; i++) begin : g_l1
    assign lvl1[i] = lvl0[2*i] + lvl0[2*i+1];
  end
  for (genvar i = 0; i < LANES/4; i++) begin : g_l2
    assign lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
  end
  for (genvar i = 0; i < LANES/8; i++) begin : g_l3
    assign lvl3[i] = lvl2[2*i] + lvl2[2*i+1];
  end
  for (genvar i = 0; i < LANES/16; i++) begin : g_l4
    assign lvl4[i] = lvl3[2*i] + lvl3[2*i+1];
  end

  assign beat_sad = lvl4[0] + lvl4[1];

endmodule

// File: rtl/intra_resid_gen.sv
// Joins one reference beat and one prediction beat, forks the result to
// independent residual / prediction / reference outputs, and accumulates a
// per-block SAD.
// Ports:
//   clk, arst                           clock, async active-high reset
//   ref_src_rsc_dat/_vld/_rdy           256-bit reference input stream
//   pred_src_rsc_dat/_vld/_rdy          256-bit prediction input stream
//   resid_out_rsc_dat/_vld/_rdy         288-bit residual output stream
//   pred_out_rsc_dat/_vld/_rdy          forwarded prediction
//   ref_out_rsc_dat/_vld/_rdy           forwarded reference
//   sad_out_rsc_dat/_vld/_rdy           18-bit block SAD, one per block
// Parameter BEATS_PER_BLOCK: beats per transform block, 1..32.
module intra_resid_gen
  import intra_resid_pkg::*;
#(
  parameter int unsigned BEATS_PER_BLOCK = 32
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [PIX_BUS_W-1:0] ref_src_rsc_dat,
  input  logic                 ref_src_rsc_vld,
  output logic                 ref_src_rsc_rdy,
  input  logic [PIX_BUS_W-1:0] pred_src_rsc_dat,
  input  logic                 pred_src_rsc_vld,
  output logic                 pred_src_rsc_rdy,
  output logic [RES_BUS_W-1:0] resid_out_rsc_dat,
  output logic                 resid_out_rsc_vld,
  input  logic                 resid_out_rsc_rdy,
  output logic [PIX_BUS_W-1:0] pred_out_rsc_dat,
  output logic                 pred_out_rsc_vld,
  input  logic                 pred_out_rsc_rdy,
  output logic [PIX_BUS_W-1:0] ref_out_rsc_dat,
  output logic                 ref_out_rsc_vld,
  input  logic                 ref_out_rsc_rdy,
  output logic [SAD_W-1:0]     sad_out_rsc_dat,
  output logic                 sad_out_rsc_vld,
  input  logic                 sad_out_rsc_rdy
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS_PER_BLOCK - 1);

  logic [RES_BUS_W-1:0]  resid;
  logic [BEAT_SAD_W-1:0] beat_sad;

  resid_lane_sad u_lane_sad (
    .ref_dat  (ref_src_rsc_dat),
    .pred_dat (pred_src_rsc_dat),
    .resid    (resid),
    .beat_sad (beat_sad)
  );

  logic [CNT_W-1:0] beat_cnt;
  logic [SAD_W-1:0] acc;
  logic [SAD_W-1:0] acc_next;
  logic             stage_free;
  logic             last_beat;
  logic             take;
  logic             join_beat;

  always_comb begin
    // Each output slot is reusable if empty or draining this cycle.
    stage_free = (!resid_out_rsc_vld || resid_out_rsc_rdy) &&
                 (!pred_out_rsc_vld  || pred_out_rsc_rdy)  &&
                 (!ref_out_rsc_vld   || ref_out_rsc_rdy);
    last_beat  = (beat_cnt == LAST_IDX);
    // An undrained block SAD only blocks the beat that would overwrite it.
    take       = stage_free && !(last_beat && sad_out_rsc_vld && !sad_out_rsc_rdy);
    join_beat  = take && ref_src_rsc_vld && pred_src_rsc_vld;
    // Beat 0 restarts the sum, which also covers single-beat blocks.
    acc_next   = ((beat_cnt == '0) ? '0 : acc) + SAD_W'(beat_sad);
  end

  // Each side is only ready when the other side is offering, so neither
  // input can be consumed alone.
  assign ref_src_rsc_rdy  = !arst && take && pred_src_rsc_vld;
  assign pred_src_rsc_rdy = !arst && take && ref_src_rsc_vld;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      resid_out_rsc_dat <= '0;
      resid_out_rsc_vld <= 1'b0;
      pred_out_rsc_dat  <= '0;
      pred_out_rsc_vld  <= 1'b0;
      ref_out_rsc_dat   <= '0;
      ref_out_rsc_vld   <= 1'b0;
      sad_out_rsc_dat   <= '0;
      sad_out_rsc_vld   <= 1'b0;
      beat_cnt          <= '0;
      acc               <= '0;
    end else begin
      if (join_beat) begin
        resid_out_rsc_dat <= resid;
        pred_out_rsc_dat  <= pred_src_rsc_dat;
        ref_out_rsc_dat   <= ref_src_rsc_dat;
        resid_out_rsc_vld <= 1'b1;
        pred_out_rsc_vld  <= 1'b1;
        ref_out_rsc_vld   <= 1'b1;
        beat_cnt          <= last_beat ? '0 : beat_cnt + 1'b1;
        acc               <= acc_next;
      end else begin
        if (resid_out_rsc_rdy) resid_out_rsc_vld <= 1'b0;
        if (pred_out_rsc_rdy)  pred_out_rsc_vld  <= 1'b0;
        if (ref_out_rsc_rdy)   ref_out_rsc_vld   <= 1'b0;
      end

      if (join_beat && last_beat) begin
        sad_out_rsc_dat <= acc_next;
        sad_out_rsc_vld <= 1'b1;
      end else if (sad_out_rsc_rdy) begin
        sad_out_rsc_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_intra_resid_gen.sv
// Self-checking bench for intra_resid_gen: table vectors, directed corner
// sequences and a randomized phase, all scored against a behavioural model.
module tb_intra_resid_gen;

  localparam int LANES = 32;
  localparam int BPB   = 32;

  logic         clk  = 1'b0;
  logic         arst = 1'b1;
  logic [255:0] ref_src_rsc_dat, pred_src_rsc_dat;
  logic         ref_src_rsc_vld, pred_src_rsc_vld;
  logic         ref_src_rsc_rdy, pred_src_rsc_rdy;
  logic [287:0] resid_out_rsc_dat;
  logic         resid_out_rsc_vld, resid_out_rsc_rdy;
  logic [255:0] pred_out_rsc_dat, ref_out_rsc_dat;
  logic         pred_out_rsc_vld, pred_out_rsc_rdy;
  logic         ref_out_rsc_vld, ref_out_rsc_rdy;
  logic [17:0]  sad_out_rsc_dat;
  logic         sad_out_rsc_vld, sad_out_rsc_rdy;

  intra_resid_gen #(.BEATS_PER_BLOCK(BPB)) dut (
    .clk               (clk),
    .arst              (arst),
    .ref_src_rsc_dat   (ref_src_rsc_dat),
    .ref_src_rsc_vld   (ref_src_rsc_vld),
    .ref_src_rsc_rdy   (ref_src_rsc_rdy),
    .pred_src_rsc_dat  (pred_src_rsc_dat),
    .pred_src_rsc_vld  (pred_src_rsc_vld),
    .pred_src_rsc_rdy  (pred_src_rsc_rdy),
    .resid_out_rsc_dat (resid_out_rsc_dat),
    .resid_out_rsc_vld (resid_out_rsc_vld),
    .resid_out_rsc_rdy (resid_out_rsc_rdy),
    .pred_out_rsc_dat  (pred_out_rsc_dat),
    .pred_out_rsc_vld  (pred_out_rsc_vld),
    .pred_out_rsc_rdy  (pred_out_rsc_rdy),
    .ref_out_rsc_dat   (ref_out_rsc_dat),
    .ref_out_rsc_vld   (ref_out_rsc_vld),
    .ref_out_rsc_rdy   (ref_out_rsc_rdy),
    .sad_out_rsc_dat   (sad_out_rsc_dat),
    .sad_out_rsc_vld   (sad_out_rsc_vld),
    .sad_out_rsc_rdy   (sad_out_rsc_rdy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: plain integer arithmetic per lane.
  function automatic logic [287:0] model_resid(input logic [255:0] r, input logic [255:0] p);
    logic [287:0] v;
    int d;
    for (int i = 0; i < LANES; i++) begin
      d = int'(r[8*i +: 8]) - int'(p[8*i +: 8]);
      v[9*i +: 9] = 9'(d);
    end
    return v;
  endfunction

  function automatic int model_sad(input logic [255:0] r, input logic [255:0] p);
    int s;
    int d;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      d = int'(r[8*i +: 8]) - int'(p[8*i +: 8]);
      s += (d < 0) ? -d : d;
    end
    return s;
  endfunction

  // Scoreboard state, owned by the monitor process only.
  logic [287:0] q_resid[$];
  logic [255:0] q_pred[$];
  logic [255:0] q_ref[$];
  logic [17:0]  q_sad[$];
  int m_cnt = 0, m_sum = 0;
  int join_count = 0, pred_hs = 0, ref_hs = 0, sad_vld_cycles = 0;
  logic [17:0]  last_sad = '0;
  logic         p_rv = 0, p_rh = 0, p_pv = 0, p_ph = 0, p_fv = 0, p_fh = 0, p_sv = 0, p_sh = 0;
  logic [287:0] p_rd = '0;
  logic [255:0] p_pd = '0, p_fd = '0;
  logic [17:0]  p_sd = '0;

  // Monitor samples at the falling edge; inputs only change just after rising edges.
  initial begin
    forever begin
      @(negedge clk);
      if (arst) begin
        chk("reset_ctrl", {resid_out_rsc_vld, pred_out_rsc_vld, ref_out_rsc_vld,
                           sad_out_rsc_vld, ref_src_rsc_rdy, pred_src_rsc_rdy}, '0);
        chk("reset_data", {|resid_out_rsc_dat, |pred_out_rsc_dat, |ref_out_rsc_dat,
                           |sad_out_rsc_dat}, '0);
        q_resid.delete(); q_pred.delete(); q_ref.delete(); q_sad.delete();
        m_cnt = 0; m_sum = 0;
        p_rv = 0; p_pv = 0; p_fv = 0; p_sv = 0;
      end else begin
        chk("join_rule", {ref_src_rsc_rdy & ~pred_src_rsc_vld,
                          pred_src_rsc_rdy & ~ref_src_rsc_vld}, '0);
        if (p_rv && !p_rh) chk("resid_hold", {resid_out_rsc_vld, resid_out_rsc_dat}, {1'b1, p_rd});
        if (p_pv && !p_ph) chk("pred_hold", {pred_out_rsc_vld, pred_out_rsc_dat}, {1'b1, p_pd});
        if (p_fv && !p_fh) chk("ref_hold", {ref_out_rsc_vld, ref_out_rsc_dat}, {1'b1, p_fd});
        if (p_sv && !p_sh) chk("sad_hold", {sad_out_rsc_vld, sad_out_rsc_dat}, {1'b1, p_sd});

        if (resid_out_rsc_vld && resid_out_rsc_rdy) begin
          if (q_resid.size() == 0) chk("resid_spurious", 1, 0);
          else chk("resid_data", resid_out_rsc_dat, q_resid.pop_front());
        end
        if (pred_out_rsc_vld && pred_out_rsc_rdy) begin
          pred_hs++;
          if (q_pred.size() == 0) chk("pred_spurious", 1, 0);
          else chk("pred_data", pred_out_rsc_dat, q_pred.pop_front());
        end
        if (ref_out_rsc_vld && ref_out_rsc_rdy) begin
          ref_hs++;
          if (q_ref.size() == 0) chk("ref_spurious", 1, 0);
          else chk("ref_data", ref_out_rsc_dat, q_ref.pop_front());
        end
        if (sad_out_rsc_vld) sad_vld_cycles++;
        if (sad_out_rsc_vld && sad_out_rsc_rdy) begin
          last_sad = sad_out_rsc_dat;
          if (q_sad.size() == 0) chk("sad_spurious", 1, 0);
          else chk("sad_data", sad_out_rsc_dat, q_sad.pop_front());
        end

        if (ref_src_rsc_vld && ref_src_rsc_rdy) begin
          join_count++;
          chk("join_both", {pred_src_rsc_vld, pred_src_rsc_rdy}, 2'b11);
          q_resid.push_back(model_resid(ref_src_rsc_dat, pred_src_rsc_dat));
          q_pred.push_back(pred_src_rsc_dat);
          q_ref.push_back(ref_src_rsc_dat);
          m_sum += model_sad(ref_src_rsc_dat, pred_src_rsc_dat);
          m_cnt++;
          if (m_cnt == BPB) begin
            q_sad.push_back(18'(m_sum));
            m_cnt = 0;
            m_sum = 0;
          end
        end

        p_rv = resid_out_rsc_vld; p_rh = resid_out_rsc_rdy; p_rd = resid_out_rsc_dat;
        p_pv = pred_out_rsc_vld;  p_ph = pred_out_rsc_rdy;  p_pd = pred_out_rsc_dat;
        p_fv = ref_out_rsc_vld;   p_fh = ref_out_rsc_rdy;   p_fd = ref_out_rsc_dat;
        p_sv = sad_out_rsc_vld;   p_sh = sad_out_rsc_rdy;   p_sd = sad_out_rsc_dat;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_const(input logic [7:0] r, input logic [7:0] p);
    ref_src_rsc_dat  = {32{r}};
    pred_src_rsc_dat = {32{p}};
  endtask

  task automatic rand_data();
    for (int i = 0; i < 8; i++) begin
      ref_src_rsc_dat[32*i +: 32]  = $urandom;
      pred_src_rsc_dat[32*i +: 32] = $urandom;
    end
  endtask

  task automatic all_rdy(input logic v);
    resid_out_rsc_rdy = v; pred_out_rsc_rdy = v; ref_out_rsc_rdy = v; sad_out_rsc_rdy = v;
  endtask

  task automatic do_reset();
    step();
    arst = 1'b1; ref_src_rsc_vld = 0; pred_src_rsc_vld = 0;
    step();
    arst = 1'b0;
  endtask

  // One full constant block with all rdy high; checks lanes, SAD value and pulse width.
  task automatic run_block(input string nm, input logic [7:0] r, input logic [7:0] p,
                           input logic [8:0] lane, input logic [17:0] exp_sad);
    int j0, s0;
    j0 = join_count; s0 = sad_vld_cycles;
    all_rdy(1'b1);
    set_const(r, p);
    ref_src_rsc_vld = 1; pred_src_rsc_vld = 1;
    @(negedge clk);
    chk({nm, "_in_rdy"}, {ref_src_rsc_rdy, pred_src_rsc_rdy}, 2'b11);
    step();
    @(negedge clk);
    chk({nm, "_resid"}, resid_out_rsc_dat, {32{lane}});
    chk({nm, "_fwd"}, {pred_out_rsc_dat, ref_out_rsc_dat}, {{32{p}}, {32{r}}});
    repeat (31) step();
    ref_src_rsc_vld = 0; pred_src_rsc_vld = 0;
    chk({nm, "_throughput"}, join_count - j0, BPB);
    chk({nm, "_sad_now"}, {sad_out_rsc_vld, sad_out_rsc_dat}, {1'b1, exp_sad});
    repeat (3) step();
    chk({nm, "_sad_pulse"}, sad_vld_cycles - s0, 1);
    chk({nm, "_sad_last"}, last_sad, exp_sad);
  endtask

  typedef struct {
    logic [7:0] r;
    logic [7:0] p;
    logic [8:0] lane;
  } vec_t;

  vec_t tv[8];
  int   j0, ph0, fh0;

  initial begin
    tv[0] = '{8'd200, 8'd50,  9'd150};
    tv[1] = '{8'd0,   8'd255, 9'h101};
    tv[2] = '{8'd255, 8'd0,   9'd255};
    tv[3] = '{8'd50,  8'd50,  9'd0};
    tv[4] = '{8'd0,   8'd1,   9'h1ff};
    tv[5] = '{8'd128, 8'd127, 9'd1};
    tv[6] = '{8'd127, 8'd128, 9'h1ff};
    tv[7] = '{8'd10,  8'd0,   9'd10};

    ref_src_rsc_dat = '0; pred_src_rsc_dat = '0;
    all_rdy(1'b1);
    // Offer beats during reset: input rdy must stay low.
    ref_src_rsc_vld = 1; pred_src_rsc_vld = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_rdy", {ref_src_rsc_rdy, pred_src_rsc_rdy}, 2'b00);
    chk("reset_out_vld", {resid_out_rsc_vld, pred_out_rsc_vld, ref_out_rsc_vld, sad_out_rsc_vld},
        4'b0000);
    step();
    ref_src_rsc_vld = 0; pred_src_rsc_vld = 0;
    arst = 1'b0;

    // Table vectors: one beat each, check the residual lanes.
    for (int i = 0; i < 8; i++) begin
      set_const(tv[i].r, tv[i].p);
      ref_src_rsc_vld = 1; pred_src_rsc_vld = 1;
      step();
      ref_src_rsc_vld = 0; pred_src_rsc_vld = 0;
      @(negedge clk);
      chk("vec_resid", resid_out_rsc_dat, {32{tv[i].lane}});
      step();
    end

    do_reset();
    run_block("blk150", 8'd200, 8'd50, 9'd150, 18'd153600);
    do_reset();
    run_block("blkmax", 8'd0, 8'd255, 9'h101, 18'd261120);

    // Reference alone must not join.
    do_reset();
    j0 = join_count;
    rand_data();
    ref_src_rsc_vld = 1; pred_src_rsc_vld = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("half_no_join", {ref_src_rsc_rdy, resid_out_rsc_vld, pred_out_rsc_vld, ref_out_rsc_vld},
          4'b0000);
      step();
    end
    chk("half_join_cnt", join_count - j0, 0);
    pred_src_rsc_vld = 1;
    @(negedge clk);
    chk("half_rdy", {ref_src_rsc_rdy, pred_src_rsc_rdy}, 2'b11);
    step();
    ref_src_rsc_vld = 0; pred_src_rsc_vld = 0;
    @(negedge clk);
    chk("half_out_vld", {resid_out_rsc_vld, pred_out_rsc_vld, ref_out_rsc_vld}, 3'b111);
    chk("half_join_one", join_count - j0, 1);
    step();

    // Residual output stalled while pred/ref drain.
    do_reset();
    j0 = join_count; ph0 = pred_hs; fh0 = ref_hs;
    resid_out_rsc_rdy = 0;
    ref_src_rsc_vld = 1; pred_src_rsc_vld = 1;
    for (int i = 0; i < 6; i++) begin
      rand_data();
      step();
    end
    @(negedge clk);
    chk("rstall_joins", join_count - j0, 1);
    chk("rstall_pred_hs", pred_hs - ph0, 1);
    chk("rstall_ref_hs", ref_hs - fh0, 1);
    chk("rstall_in_rdy", {ref_src_rsc_rdy, pred_src_rsc_rdy}, 2'b00);
    step();
    resid_out_rsc_rdy = 1;
    @(negedge clk);
    chk("rstall_release_rdy", {ref_src_rsc_rdy, pred_src_rsc_rdy}, 2'b11);
    step();
    ref_src_rsc_vld = 0; pred_src_rsc_vld = 0;
    repeat (2) step();
    chk("rstall_joins2", join_count - j0, 2);

    // SAD held at block end: block 2 beats 0..30 flow, beat 31 waits.
    do_reset();
    j0 = join_count;
    sad_out_rsc_rdy = 0;
    ref_src_rsc_vld = 1; pred_src_rsc_vld = 1;
    for (int i = 0; i < 70; i++) begin
      rand_data();
      step();
    end
    @(negedge clk);
    chk("sstall_joins", join_count - j0, 63);
    chk("sstall_in_rdy", ref_src_rsc_rdy, 0);
    chk("sstall_sad_vld", sad_out_rsc_vld, 1);
    step();
    sad_out_rsc_rdy = 1;
    @(negedge clk);
    chk("sstall_release_rdy", ref_src_rsc_rdy, 1);
    step();
    ref_src_rsc_vld = 0; pred_src_rsc_vld = 0;
    chk("sstall_reload_vld", sad_out_rsc_vld, 1);
    repeat (3) step();
    chk("sstall_joins2", join_count - j0, 64);
    chk("sstall_sad_q", q_sad.size(), 0);

    // Reset in mid-block discards the partial sum.
    do_reset();
    ref_src_rsc_vld = 1; pred_src_rsc_vld = 1;
    for (int i = 0; i < 11; i++) begin
      rand_data();
      step();
    end
    arst = 1'b1;
    ref_src_rsc_vld = 0; pred_src_rsc_vld = 0;
    @(negedge clk);
    chk("midrst_zero", {|resid_out_rsc_dat, |pred_out_rsc_dat, |ref_out_rsc_dat,
                        |sad_out_rsc_dat, resid_out_rsc_vld, pred_out_rsc_vld,
                        ref_out_rsc_vld, sad_out_rsc_vld}, '0);
    step();
    arst = 1'b0;
    run_block("midrst", 8'd10, 8'd0, 9'd10, 18'd10240);

    // Randomized traffic with toggling downstream rdy.
    do_reset();
    j0 = join_count;
    for (int i = 0; i < 3000; i++) begin
      rand_data();
      ref_src_rsc_vld   = ($urandom_range(3) != 0);
      pred_src_rsc_vld  = ($urandom_range(3) != 0);
      resid_out_rsc_rdy = ($urandom_range(2) != 0);
      pred_out_rsc_rdy  = ($urandom_range(2) != 0);
      ref_out_rsc_rdy   = ($urandom_range(2) != 0);
      sad_out_rsc_rdy   = ($urandom_range(3) == 0);
      step();
    end
    ref_src_rsc_vld = 0; pred_src_rsc_vld = 0;
    all_rdy(1'b1);
    repeat (4) step();
    chk("rand_activity", (join_count - j0) > 500, 1);
    chk("drain_queues", {q_resid.size() == 0, q_pred.size() == 0, q_ref.size() == 0,
                         q_sad.size() == 0}, 4'b1111);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intra_resid_gen.md
# intra_resid_gen

Upstream stage of the intra search transform chain. Joins one beat of reference pixels and one beat of predicted pixels, 32 lanes of 8 bits each. Forks the joined beat to three outputs:
- the 288-bit residual for the forward transform,
- the untouched prediction for reconstruction,
- the untouched reference for reconstruction.

It also accumulates a per-block SAD for intra mode decision. All outputs are registered, and each output handshake completes independently.

## Interface
Parameters:
- BEATS_PER_BLOCK, default 32: beats per transform block; legal range 1..32.

Ports:
- clk  in  1  single clock, rising edge.
- arst  in  1  reset; asynchronous, active-high.
- ref_src_rsc_dat  in  256  reference pixels; lane i at [8i+7:8i], unsigned.
- ref_src_rsc_vld  in  1  reference beat valid.
- ref_src_rsc_rdy  out  1  reference beat accepted.
- pred_src_rsc_dat  in  256  predicted pixels; same lane layout.
- pred_src_rsc_vld  in  1  prediction beat valid.
- pred_src_rsc_rdy  out  1  prediction beat accepted.
- resid_out_rsc_dat / _vld out, _rdy in  288/1/1  residual beat; lane i at [9i+8:9i], two's complement.
- pred_out_rsc_dat / _vld out, _rdy in  256/1/1  forwarded prediction.
- ref_out_rsc_dat / _vld out, _rdy in  256/1/1  forwarded reference.
- sad_out_rsc_dat / _vld out, _rdy in  18/1/1  block SAD, unsigned.

## Operation
- Join:
  - A beat is taken only when ref_src_rsc_vld, pred_src_rsc_vld and `take` are all 1.
  - Both input rdy outputs equal `take && other_vld`, so neither input is consumed alone.
- Residual per lane: resid_i = {1'b0,ref_i} - {1'b0,pred_i}, 9 bits, range -255..255, no saturation.
- Beat SAD: sum over lanes of |resid_i|, 13 bits (max 8160).
- Output stage:
  - One register set holds resid, pred and ref, with three valid flags vr, vp, vf.
  - Each flag clears on its own vld&rdy handshake.
  - The stage is free when every flag is either clear or being handshaked this cycle.
  - take = stage_free && !(last_beat && sad_out_rsc_vld && !sad_out_rsc_rdy).
- Block accounting:
  - beat_cnt runs 0..BEATS_PER_BLOCK-1. It increments on each joined beat and wraps to 0 after the last beat.
  - acc (18 bits) is loaded with the beat SAD on beat 0 and adds the beat SAD on later beats.
  - On the last beat, sad_out_rsc_dat <= acc + beat SAD and sad_out_rsc_vld <= 1. The flag clears on handshake.
  - The maximum block SAD is 261120, which fits in 18 bits. No overflow is possible in the legal parameter range.
- Reset (arst=1): all four vld outputs 0, all data outputs 0, beat_cnt 0, acc 0. Input rdy outputs read 0 while arst is high.
- Reset mid-block discards the partial block. The next joined beat is beat 0.

## Timing
- Latency: a beat joined at edge N presents all three stream outputs valid after edge N. The SAD is valid after the edge that joins the last beat.
- Throughput: one beat per cycle when all downstream rdy are held high.
- Input rdy is combinational from downstream rdy and the valid flags; there is no bubble on back-to-back drain.
- Simultaneous events:
  - Handshake of the last pending output and a new join in the same cycle: the register reloads and the flags stay 1.
  - A SAD handshake in the same cycle as the next block's last beat: the last beat is accepted and sad_out reloads.
- Downstream rdy may toggle freely. Data on any output with vld=1 is stable until its handshake.
- The block never drops or duplicates a beat on any output.

## Structure
- Shared package intra_resid_pkg holds these constants: LANES=32, PIX_W=8, RES_W=9, BEAT_SAD_W=13, SAD_W=18.
- One sub-module, resid_lane_sad: purely combinational. It takes the 256-bit ref and 256-bit pred and produces the 288-bit residual and the 13-bit beat SAD through an adder tree.
- The top level holds the join/fork control, output registers, beat counter and accumulator.

## Test plan
- Reset, then ref lanes all 200 and pred lanes all 50 with all rdy high: resid lanes 9'd150, pred/ref forwarded unchanged. After 32 beats sad_out = 32*32*150 = 153600, valid for exactly one cycle.
- ref=0 and pred=255 on every lane for a full block: resid lanes 9'h101 (-255), sad_out = 261120 (no overflow).
- ref_src valid with pred_src low for 5 cycles: neither input rdy pulses and no output goes valid. Raising pred_src joins in one cycle.
- Hold resid_out_rsc_rdy=0 while pred/ref drain: pred_out and ref_out pulse once, and input rdy stays 0 until resid handshakes. There are no duplicate pred/ref beats.
- Hold sad_out_rsc_rdy=0 at the end of block 1: beats 0..30 of block 2 flow and beat 31 stalls until the SAD handshake. The block 2 SAD is then correct.
- Assert arst after beat 10 of a block, then run a full block of ref=10, pred=0: sad_out = 10240. All outputs are 0 during reset.
